// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: loads one 16-word block, then streams W[0..ROUNDS-1]
// from a 16-word sliding window over a backpressurable valid/ready output.
module sha2_msg_schedule #(
   parameter bit SHA512 = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear_in,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [(SHA512 ? 64 : 32)-1:0]   in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [(SHA512 ? 64 : 32)-1:0]   out_data,
   output logic [6:0]                      out_round,
   output logic                            out_last,
   output logic                            busy
);

   localparam int W      = SHA512 ? 64 : 32;
   localparam int ROUNDS = SHA512 ? 80 : 64;

   typedef enum logic {LOAD, EXPAND} state_t;

   state_t       state;
   logic [3:0]   ld_cnt;
   logic [6:0]   t;
   logic [W-1:0] win [16];
   logic [W-1:0] nxt;

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
      logic [2*W-1:0] d;
      d = {x, x} >> n;
      return d[W-1:0];
   endfunction

   function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
      return SHA512 ? (rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7))
                    : (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3));
   endfunction

   function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
      return SHA512 ? (rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6))
                    : (rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10));
   endfunction

   // W[t+16] from the window holding W[t..t+15]
   assign nxt = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   assign out_data  = win[0];
   assign out_round = t;
   assign out_last  = out_valid && (t == 7'(ROUNDS-1));
   assign busy      = (state != LOAD) || (ld_cnt != 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         ld_cnt    <= 4'd0;
         t         <= 7'd0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (clear_in) begin
         state     <= LOAD;
         ld_cnt    <= 4'd0;
         t         <= 7'd0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid && in_ready) begin
                  win[ld_cnt] <= in_data;
                  ld_cnt      <= ld_cnt + 4'd1;
                  if (ld_cnt == 4'd15) begin
                     state     <= EXPAND;
                     t         <= 7'd0;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                  end
               end
            end
            EXPAND: begin
               if (out_valid && out_ready) begin
                  for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                  win[15] <= nxt;
                  t       <= t + 7'd1;
                  if (t == 7'(ROUNDS-1)) begin
                     state     <= LOAD;
                     t         <= 7'd0;
                     ld_cnt    <= 4'd0;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
